// File: rtl/mem_reduce_unit_pkg.sv
// Shared constants and FSM state encoding for the memory sweep/reduce controller.
package mem_reduce_unit_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned SUM_W  = DATA_W + ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUM  = 2'd1,
    WB   = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/mem_reduce_unit.sv
// Controller owning the register memory ports: forwards host writes while idle,
// sweeps two entries per cycle into an unsigned sum, optionally writes it back.
module mem_reduce_unit #(
  parameter int unsigned DATA_W    = mem_reduce_unit_pkg::DATA_W,
  parameter int unsigned ADDR_W    = mem_reduce_unit_pkg::ADDR_W,
  parameter int unsigned SUM_W     = mem_reduce_unit_pkg::SUM_W,
  parameter int unsigned WRITEBACK = 1,
  parameter int unsigned WB_ADDR   = 15
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              start,
  input  logic              wrReq,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  output logic              wrAccept,
  output logic              memWriteEnable,
  output logic [ADDR_W-1:0] memWriteAddress,
  output logic [DATA_W-1:0] memWriteData,
  output logic [ADDR_W-1:0] memReadAddress1,
  output logic [ADDR_W-1:0] memReadAddress2,
  input  logic [DATA_W-1:0] memReadData1,
  input  logic [DATA_W-1:0] memReadData2,
  output logic [SUM_W-1:0]  sum,
  output logic              busy,
  output logic              done
);

  import mem_reduce_unit_pkg::state_e;
  import mem_reduce_unit_pkg::IDLE;
  import mem_reduce_unit_pkg::SUM;
  import mem_reduce_unit_pkg::WB;
  import mem_reduce_unit_pkg::DONE;

  localparam int unsigned DEPTH = 1 << ADDR_W;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [SUM_W-1:0]    acc_q, acc_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic                busy_q, done_q;
  logic                we_c;
  logic [ADDR_W-1:0]   waddr_c;
  logic [DATA_W-1:0]   wdata_c;
  logic                accept_c;

  // State, pointer, accumulator and registered status flags
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      busy_q  <= (state_d == SUM) || (state_d == WB);
      done_q  <= (state_d == DONE);
    end
  end

  // Next state, datapath updates and memory write port mux
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    acc_d    = acc_q;
    sum_d    = sum_q;
    we_c     = 1'b0;
    waddr_c  = wrAddr;
    wdata_c  = wrData;
    accept_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Host writes are gated while reset is held so nothing lands mid-reset
        accept_c = wrReq & resetN;
        we_c     = wrReq & resetN;
        if (start) begin
          state_d = SUM;
          acc_d   = '0;
          ptr_d   = '0;
        end
      end
      SUM: begin
        acc_d = acc_q + SUM_W'(memReadData1) + SUM_W'(memReadData2);
        ptr_d = ptr_q + ADDR_W'(2);
        if (ptr_q == ADDR_W'(DEPTH - 2)) begin
          sum_d   = acc_d;
          ptr_d   = '0;
          state_d = (WRITEBACK != 0) ? WB : DONE;
        end
      end
      WB: begin
        we_c    = 1'b1;
        waddr_c = ADDR_W'(WB_ADDR);
        wdata_c = acc_q[DATA_W-1:0];
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign wrAccept        = accept_c;
  assign memWriteEnable  = we_c;
  assign memWriteAddress = waddr_c;
  assign memWriteData    = wdata_c;
  assign memReadAddress1 = ptr_q;
  assign memReadAddress2 = ptr_q + ADDR_W'(1);
  assign sum             = sum_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule
